// File: rtl/ext_mem_port_arbiter.sv
// Arbitrates independent chip read/write streams onto one single-port external memory,
// with a small write buffer (read forwarding, drain, flush) and saturating beat counters.
module ext_mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WBUF_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_qout,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_din,
  output logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_qout,
  input  logic                  flush_req,
  output logic                  flush_done,
  input  logic                  clear_counts,
  output logic [CNT_WIDTH-1:0]  rd_beats,
  output logic [CNT_WIDTH-1:0]  wr_beats
);
  localparam int unsigned PW = $clog2(WBUF_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic                  active;
  logic [ADDR_WIDTH-1:0] buf_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data [WBUF_DEPTH];
  logic [PW-1:0]         head, tail, idx;
  logic [PW:0]           count;
  logic                  full, empty, rd_acc, wr_acc, hit, pop;
  logic [DATA_WIDTH-1:0] hit_data, fwd_data;
  logic                  fwd_q;

  assign full  = (count == (PW+1)'(WBUF_DEPTH));
  assign empty = (count == '0);

  // Holds the ready outputs low while reset is asserted and for the first edge after it.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) active <= 1'b0;
    else            active <= 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state <= RUN;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush_req) state_nxt = FLUSH;
      FLUSH:   if (empty)     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    rd_ready   = 1'b0;
    wr_ready   = 1'b0;
    flush_done = 1'b0;
    if (active && state == RUN) begin
      rd_ready = !full;
      wr_ready = !full;
    end
    if (state == FLUSH) flush_done = empty;
  end

  // Scan oldest to youngest over entries present before this cycle's push; last hit wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      idx = head + PW'(i);
      if ((PW+1)'(i) < count && buf_addr[idx] == rd_addr) begin
        hit      = 1'b1;
        hit_data = buf_data[idx];
      end
    end
  end

  assign rd_acc = rd_en && rd_ready;
  assign wr_acc = wr_en && wr_ready;
  assign mem_re = rd_acc && !hit;
  assign pop    = !empty && !mem_re;
  assign mem_we = pop;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    if (mem_re) begin
      mem_addr = rd_addr;
    end else if (pop) begin
      mem_addr = buf_addr[head];
      mem_din  = buf_data[head];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      buf_addr[tail] <= wr_addr;
      buf_data[tail] <= wr_din;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)    head <= head + 1'b1;
      if (wr_acc) tail <= tail + 1'b1;
      count <= count + (PW+1)'(wr_acc) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      rd_valid <= 1'b0;
      fwd_q    <= 1'b0;
      fwd_data <= '0;
    end else begin
      rd_valid <= rd_acc;
      fwd_q    <= rd_acc && hit;
      if (rd_acc) fwd_data <= hit_data;
    end
  end

  assign rd_qout = !rd_valid ? '0 : (fwd_q ? fwd_data : mem_qout);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      rd_beats <= '0;
      wr_beats <= '0;
    end else if (clear_counts) begin
      rd_beats <= '0;
      wr_beats <= '0;
    end else begin
      if (mem_re && rd_beats != '1) rd_beats <= rd_beats + 1'b1;
      if (mem_we && wr_beats != '1) wr_beats <= wr_beats + 1'b1;
    end
  end
endmodule
